// File: rtl/hbm_edge_rqst_gen.sv
// Purpose  : expands one active vertex edge range [loffset, roffset) into consecutive HBM line
//            read requests, each carrying a per-edge valid mask and the owning vertex id.
// Latency  : vertex pushed -> FIFO pop (IDLE) -> LOAD -> ISSUE; requests leave a register, 1 line/cycle.
// Backpres.: next_stage_full freezes issue with no loss. stage_full is registered (FIFO non-empty).
//            A write into a full 2-entry FIFO is dropped and sets sticky rqst_overflow.
//
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   front_active_v_*            vertex input (id, loffset inclusive, roffset exclusive, valid)
//   next_stage_full             downstream send stage cannot take a request this cycle
//   stage_full                  registered backpressure to upstream
//   rd_hbm_edge_addr/mask/v_id  request payload, holds its last value while valid is low
//   rd_hbm_edge_valid           one-cycle pulse per request
//   rqst_overflow               sticky, set when a vertex was dropped at a full FIFO
// Optional build macro HBM_RQST_STAT_EN adds stat_v_cnt (vertices popped, incl. zero-degree)
// and stat_line_cnt (requests issued); both are free-running 32-bit counters.

module hbm_edge_rqst_gen #(
    parameter int          V_ID_WIDTH        = 20,
    parameter int          V_OFF_DWIDTH      = 32,
    parameter int          HBM_AWIDTH        = 32,
    parameter int          EDGE_PER_LINE_LOG = 4,
    parameter int unsigned HBM_BASE_LINE     = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [V_ID_WIDTH-1:0]               front_active_v_id,
    input  logic [V_OFF_DWIDTH-1:0]             front_active_v_loffset,
    input  logic [V_OFF_DWIDTH-1:0]             front_active_v_roffset,
    input  logic                                front_active_v_valid,
    input  logic                                next_stage_full,
    output logic                                stage_full,
    output logic [HBM_AWIDTH-1:0]               rd_hbm_edge_addr,
    output logic [(2**EDGE_PER_LINE_LOG)-1:0]   rd_hbm_edge_mask,
    output logic [V_ID_WIDTH-1:0]               rd_hbm_edge_v_id,
    output logic                                rd_hbm_edge_valid,
    output logic                                rqst_overflow
`ifdef HBM_RQST_STAT_EN
    ,
    output logic [31:0]                         stat_v_cnt,
    output logic [31:0]                         stat_line_cnt
`endif
);

    localparam int L   = EDGE_PER_LINE_LOG;
    localparam int EPL = 2 ** EDGE_PER_LINE_LOG;
    localparam int LW  = V_OFF_DWIDTH - EDGE_PER_LINE_LOG;   // line index width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input FIFO storage (2 entries, pointer based)
    // ------------------------------------------------------------------
    logic [V_ID_WIDTH-1:0]   fifo_id_q   [2];
    logic [V_ID_WIDTH-1:0]   fifo_id_d   [2];
    logic [V_OFF_DWIDTH-1:0] fifo_loff_q [2];
    logic [V_OFF_DWIDTH-1:0] fifo_loff_d [2];
    logic [V_OFF_DWIDTH-1:0] fifo_roff_q [2];
    logic [V_OFF_DWIDTH-1:0] fifo_roff_d [2];
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic [1:0]              count_q, count_d;

    logic                    pop;
    logic                    push_ok;
    logic                    ovf_set;

    // ------------------------------------------------------------------
    // Vertex context latched at pop time
    // ------------------------------------------------------------------
    state_t                  state_q, state_d;
    logic [LW-1:0]           sl_q, sl_d;
    logic [LW-1:0]           el_q, el_d;
    logic [LW-1:0]           cur_line_q, cur_line_d;
    logic [L-1:0]            first_bit_q, first_bit_d;
    logic [L-1:0]            last_bit_q, last_bit_d;
    logic [V_ID_WIDTH-1:0]   cur_vid_q, cur_vid_d;
    logic                    zero_q, zero_d;

    // Registered outputs
    logic                    rd_vld_q, rd_vld_d;
    logic [HBM_AWIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [EPL-1:0]          rd_mask_q, rd_mask_d;
    logic [V_ID_WIDTH-1:0]   rd_vid_q, rd_vid_d;
    logic                    stage_full_q, stage_full_d;
    logic                    ovf_q, ovf_d;

    // FIFO head view
    logic [V_ID_WIDTH-1:0]   head_id;
    logic [V_OFF_DWIDTH-1:0] head_loff;
    logic [V_OFF_DWIDTH-1:0] head_roff;
    logic [V_OFF_DWIDTH-1:0] head_last;
    logic                    head_zero;

    // Current line payload
    logic [HBM_AWIDTH-1:0]   line_addr;
    logic [EPL-1:0]          line_mask;

    always_comb begin
        head_id   = fifo_id_q[rd_ptr_q];
        head_loff = fifo_loff_q[rd_ptr_q];
        head_roff = fifo_roff_q[rd_ptr_q];
        head_last = head_roff - V_OFF_DWIDTH'(1);
        // An inverted range is treated like an empty one so it can never run away.
        head_zero = (head_roff <= head_loff);
    end

    // ------------------------------------------------------------------
    // FIFO next state. A push while full is only legal if the head is
    // leaving in the same cycle; then the freed slot is the one written.
    // ------------------------------------------------------------------
    always_comb begin
        fifo_id_d   = fifo_id_q;
        fifo_loff_d = fifo_loff_q;
        fifo_roff_d = fifo_roff_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        push_ok = front_active_v_valid && ((count_q != 2'd2) || pop);
        ovf_set = front_active_v_valid && (count_q == 2'd2) && !pop;

        if (push_ok) begin
            fifo_id_d[wr_ptr_q]   = front_active_v_id;
            fifo_loff_d[wr_ptr_q] = front_active_v_loffset;
            fifo_roff_d[wr_ptr_q] = front_active_v_roffset;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({push_ok, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        stage_full_d = (count_d != 2'd0);
        ovf_d        = ovf_q | ovf_set;
    end

    // ------------------------------------------------------------------
    // Line payload for cur_line: edges below loffset are masked on the
    // first line, edges at/after roffset are masked on the last line.
    // ------------------------------------------------------------------
    always_comb begin
        line_addr = HBM_AWIDTH'(HBM_BASE_LINE) + HBM_AWIDTH'(cur_line_q);
        line_mask = '0;
        for (int i = 0; i < EPL; i++) begin
            line_mask[i] = ((cur_line_q != sl_q) || (i >= int'(first_bit_q))) &&
                           ((cur_line_q != el_q) || (i <= int'(last_bit_q)));
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        sl_d        = sl_q;
        el_d        = el_q;
        cur_line_d  = cur_line_q;
        first_bit_d = first_bit_q;
        last_bit_d  = last_bit_q;
        cur_vid_d   = cur_vid_q;
        zero_d      = zero_q;
        rd_vld_d    = 1'b0;
        rd_addr_d   = rd_addr_q;
        rd_mask_d   = rd_mask_q;
        rd_vid_d    = rd_vid_q;

        case (state_q)
            IDLE: begin
                if (count_q != 2'd0) begin
                    pop     = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = zero_q ? IDLE : ISSUE;
            end
            ISSUE: begin
                // A stalled cycle simply leaves cur_line where it is.
                if (!next_stage_full) begin
                    rd_vld_d   = 1'b1;
                    rd_addr_d  = line_addr;
                    rd_mask_d  = line_mask;
                    rd_vid_d   = cur_vid_q;
                    cur_line_d = cur_line_q + LW'(1);
                    if (cur_line_q == el_q) begin
                        if (count_q != 2'd0) begin
                            pop     = 1'b1;
                            state_d = LOAD;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Context for the next vertex is captured from the FIFO head as it leaves.
        if (pop) begin
            sl_d        = head_loff[V_OFF_DWIDTH-1:L];
            el_d        = head_last[V_OFF_DWIDTH-1:L];
            cur_line_d  = head_loff[V_OFF_DWIDTH-1:L];
            first_bit_d = head_loff[L-1:0];
            last_bit_d  = head_last[L-1:0];
            cur_vid_d   = head_id;
            zero_d      = head_zero;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_id_q[i]   <= '0;
                fifo_loff_q[i] <= '0;
                fifo_roff_q[i] <= '0;
            end
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            state_q      <= IDLE;
            sl_q         <= '0;
            el_q         <= '0;
            cur_line_q   <= '0;
            first_bit_q  <= '0;
            last_bit_q   <= '0;
            cur_vid_q    <= '0;
            zero_q       <= 1'b0;
            rd_vld_q     <= 1'b0;
            rd_addr_q    <= '0;
            rd_mask_q    <= '0;
            rd_vid_q     <= '0;
            stage_full_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            fifo_id_q    <= fifo_id_d;
            fifo_loff_q  <= fifo_loff_d;
            fifo_roff_q  <= fifo_roff_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            sl_q         <= sl_d;
            el_q         <= el_d;
            cur_line_q   <= cur_line_d;
            first_bit_q  <= first_bit_d;
            last_bit_q   <= last_bit_d;
            cur_vid_q    <= cur_vid_d;
            zero_q       <= zero_d;
            rd_vld_q     <= rd_vld_d;
            rd_addr_q    <= rd_addr_d;
            rd_mask_q    <= rd_mask_d;
            rd_vid_q     <= rd_vid_d;
            stage_full_q <= stage_full_d;
            ovf_q        <= ovf_d;
        end
    end

    assign stage_full        = stage_full_q;
    assign rd_hbm_edge_addr  = rd_addr_q;
    assign rd_hbm_edge_mask  = rd_mask_q;
    assign rd_hbm_edge_v_id  = rd_vid_q;
    assign rd_hbm_edge_valid = rd_vld_q;
    assign rqst_overflow     = ovf_q;

`ifdef HBM_RQST_STAT_EN
    logic [31:0] stat_v_cnt_q, stat_v_cnt_d;
    logic [31:0] stat_line_cnt_q, stat_line_cnt_d;

    // Every pop counts as a vertex, zero-degree ones included; every valid pulse is a line.
    always_comb begin
        stat_v_cnt_d    = stat_v_cnt_q + {31'd0, pop};
        stat_line_cnt_d = stat_line_cnt_q + {31'd0, rd_vld_d};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_v_cnt_q    <= '0;
            stat_line_cnt_q <= '0;
        end else begin
            stat_v_cnt_q    <= stat_v_cnt_d;
            stat_line_cnt_q <= stat_line_cnt_d;
        end
    end

    assign stat_v_cnt    = stat_v_cnt_q;
    assign stat_line_cnt = stat_line_cnt_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_hbm_edge_rqst_gen.sv
// Bench for hbm_edge_rqst_gen: expected requests are queued when a vertex is driven and
// compared in order as valid pulses appear; directed steps cover stall, zero degree,
// FIFO overflow and reset mid-burst.

module tb_hbm_edge_rqst_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] front_active_v_id;
    logic [31:0] front_active_v_loffset;
    logic [31:0] front_active_v_roffset;
    logic        front_active_v_valid;
    logic        next_stage_full;
    logic        stage_full;
    logic [31:0] rd_hbm_edge_addr;
    logic [15:0] rd_hbm_edge_mask;
    logic [19:0] rd_hbm_edge_v_id;
    logic        rd_hbm_edge_valid;
    logic        rqst_overflow;
`ifdef HBM_RQST_STAT_EN
    logic [31:0] stat_v_cnt;
    logic [31:0] stat_line_cnt;
`endif

    always #5 clk = ~clk;

    hbm_edge_rqst_gen dut (
        .clk                    (clk),
        .rst                    (rst),
        .front_active_v_id      (front_active_v_id),
        .front_active_v_loffset (front_active_v_loffset),
        .front_active_v_roffset (front_active_v_roffset),
        .front_active_v_valid   (front_active_v_valid),
        .next_stage_full        (next_stage_full),
        .stage_full             (stage_full),
        .rd_hbm_edge_addr       (rd_hbm_edge_addr),
        .rd_hbm_edge_mask       (rd_hbm_edge_mask),
        .rd_hbm_edge_v_id       (rd_hbm_edge_v_id),
        .rd_hbm_edge_valid      (rd_hbm_edge_valid),
        .rqst_overflow          (rqst_overflow)
`ifdef HBM_RQST_STAT_EN
        ,
        .stat_v_cnt             (stat_v_cnt),
        .stat_line_cnt          (stat_line_cnt)
`endif
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] mask;
        logic [19:0] vid;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk   = 0;
    int   n_err   = 0;
    int   rcv_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] addr, input logic [15:0] mask, input logic [19:0] vid);
        exp_t e;
        e.addr = addr;
        e.mask = mask;
        e.vid  = vid;
        exp_q.push_back(e);
    endtask

    // Reference: walk every edge of each touched line and keep those inside [loff, roff).
    task automatic model_vertex(input logic [19:0] id, input int unsigned loff, input int unsigned roff);
        logic [15:0] m;
        int unsigned e;
        if (roff > loff) begin
            for (int unsigned ln = loff / 16; ln <= (roff - 1) / 16; ln++) begin
                m = '0;
                for (int b = 0; b < 16; b++) begin
                    e = ln * 16 + b;
                    if (e >= loff && e < roff) m[b] = 1'b1;
                end
                push_exp(ln, m, id);
            end
        end
    endtask

    task automatic drive_v(input logic [19:0] id, input int unsigned loff, input int unsigned roff);
        front_active_v_id      = id;
        front_active_v_loffset = loff;
        front_active_v_roffset = roff;
        front_active_v_valid   = 1'b1;
    endtask

    task automatic send_v(input logic [19:0] id, input int unsigned loff, input int unsigned roff);
        @(negedge clk);
        drive_v(id, loff, roff);
        @(negedge clk);
        front_active_v_valid = 1'b0;
    endtask

    task automatic wait_rcv(input int target, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            #1;
            if (rcv_cnt >= target) done = 1'b1;
        end
        if (!done) chk("wait_rcv_timeout", 64'(rcv_cnt), 64'(target));
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard: every valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst === 1'b1 && rd_hbm_edge_valid === 1'b1) begin
            rcv_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_req", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("req_addr", 64'(rd_hbm_edge_addr), 64'(e.addr));
                chk("req_mask", 64'(rd_hbm_edge_mask), 64'(e.mask));
                chk("req_vid",  64'(rd_hbm_edge_v_id), 64'(e.vid));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int base;
        int unsigned lo;
        int unsigned deg;

        rst                    = 1'b0;
        front_active_v_id      = '0;
        front_active_v_loffset = '0;
        front_active_v_roffset = '0;
        front_active_v_valid   = 1'b0;
        next_stage_full        = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid",      64'(rd_hbm_edge_valid), 64'd0);
        chk("rst_addr",       64'(rd_hbm_edge_addr),  64'd0);
        chk("rst_mask",       64'(rd_hbm_edge_mask),  64'd0);
        chk("rst_vid",        64'(rd_hbm_edge_v_id),  64'd0);
        chk("rst_stage_full", 64'(stage_full),        64'd0);
        chk("rst_overflow",   64'(rqst_overflow),     64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single line: edges 3..6 of line 0
        push_exp(32'd0, 16'h0078, 20'd1);
        send_v(20'd1, 3, 7);
        drain("drain_single", 50);

        // Multi line: 14..34 spans lines 0,1,2 on consecutive cycles
        push_exp(32'd0, 16'hC000, 20'd2);
        push_exp(32'd1, 16'hFFFF, 20'd2);
        push_exp(32'd2, 16'h0007, 20'd2);
        base = rcv_cnt;
        send_v(20'd2, 14, 35);
        wait_rcv(base + 1, 50);
        repeat (2) begin
            @(negedge clk);
            chk("multi_consecutive", 64'(rd_hbm_edge_valid), 64'd1);
        end
        drain("drain_multi", 50);

        // Stall for 5 cycles after 2 of 6 lines, then 4 back-to-back lines
        model_vertex(20'd3, 0, 96);
        base = rcv_cnt;
        send_v(20'd3, 0, 96);
        wait_rcv(base + 2, 50);
        next_stage_full = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", 64'(rd_hbm_edge_valid), 64'd0);
        end
        next_stage_full = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("resume_valid", 64'(rd_hbm_edge_valid), 64'd1);
        end
        drain("drain_stall", 50);

        // Zero degree: popped, nothing issued
        base = rcv_cnt;
        send_v(20'd4, 40, 40);
        repeat (10) @(negedge clk);
        chk("zero_deg_reqs",       64'(rcv_cnt - base), 64'd0);
        chk("zero_deg_stage_full", 64'(stage_full),     64'd0);
`ifdef HBM_RQST_STAT_EN
        chk("stat_v_cnt",    64'(stat_v_cnt),    64'd4);
        chk("stat_line_cnt", 64'(stat_line_cnt), 64'd10);
`endif

        // Backpressure: 3 back-to-back vertices while an 8-line burst is issuing
        model_vertex(20'd5, 0, 128);
        base = rcv_cnt;
        send_v(20'd5, 0, 128);
        wait_rcv(base + 1, 50);
        @(negedge clk);
        drive_v(20'd6, 16, 20);
        model_vertex(20'd6, 16, 20);
        @(negedge clk);
        chk("bp_stage_full", 64'(stage_full), 64'd1);
        drive_v(20'd7, 33, 34);
        model_vertex(20'd7, 33, 34);
        @(negedge clk);
        chk("bp_ovf_before", 64'(rqst_overflow), 64'd0);
        drive_v(20'd8, 50, 60);                // FIFO full: must be dropped
        @(negedge clk);
        front_active_v_valid = 1'b0;
        #1;
        chk("bp_ovf_set", 64'(rqst_overflow), 64'd1);
        drain("drain_bp", 100);
        chk("bp_ovf_sticky",      64'(rqst_overflow), 64'd1);
        chk("bp_stage_full_idle", 64'(stage_full),    64'd0);

        // Reset after 2 lines of a 4-line burst
        model_vertex(20'd9, 0, 64);
        base = rcv_cnt;
        send_v(20'd9, 0, 64);
        wait_rcv(base + 2, 50);
        rst = 1'b0;
        #1;
        chk("mid_rst_valid",      64'(rd_hbm_edge_valid), 64'd0);
        chk("mid_rst_addr",       64'(rd_hbm_edge_addr),  64'd0);
        chk("mid_rst_mask",       64'(rd_hbm_edge_mask),  64'd0);
        chk("mid_rst_vid",        64'(rd_hbm_edge_v_id),  64'd0);
        chk("mid_rst_overflow",   64'(rqst_overflow),     64'd0);
        chk("mid_rst_stage_full", 64'(stage_full),        64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        base = rcv_cnt;
        repeat (20) @(negedge clk);
        chk("post_rst_reqs", 64'(rcv_cnt - base), 64'd0);

        // Recovery with a handful of random ranges
        for (int k = 0; k < 6; k++) begin
            lo  = $urandom_range(0, 300);
            deg = $urandom_range(0, 40);
            model_vertex(20'(100 + k), lo, lo + deg);
            send_v(20'(100 + k), lo, lo + deg);
            drain("drain_random", 100);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
